// File: rtl/dmem_pipe.sv
// dmem_pipe: single-outstanding byte-enabled data memory with fixed response latency.
// Define DMEM_MISALIGN_CHK_EN to reject misaligned accesses with rsp_err.
module dmem_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] CNT_INIT = 2'((LATENCY > 1) ? LATENCY - 2 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic accept, misalign, wr_en, unused_addr;
  assign req_ready = (state_q == IDLE);
  assign accept = req_valid && req_ready;
  assign idx = req_addr[IDX_W+1:2];
  assign unused_addr = ^req_addr;
`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign = (req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign wr_en = accept && req_we && !misalign;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = (LATENCY == 1) ? RESP : WAIT;
        cnt_d = CNT_INIT;
        rdata_d = (req_we || misalign) ? '0 : mem[idx];
        err_d = misalign;
      end
      WAIT: begin
        state_d = (cnt_q == 2'd0) ? RESP : WAIT;
        cnt_d = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= 2'd0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W / 8; i++)
      if (wr_en && req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
  end
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
endmodule

// File: doc/dmem_pipe.md
DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 64, number of words (power of 2, >=2).
REQ-004 SHALL have parameter LATENCY, default 1, cycles from request accept to response valid (1..4).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  block can accept a request.
REQ-009 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  input  DATA_W  write data.
REQ-012 SHALL have port req_be  input  DATA_W/8  byte enables for writes.
REQ-013 SHALL have port rsp_valid  output  1  response present.
REQ-014 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-015 SHALL have port rsp_rdata  output  DATA_W  read data (0 for write responses).
REQ-016 SHALL have port rsp_err  output  1  response error flag.

Function
REQ-017 SHALL implement states IDLE, WAIT, RESP; req_ready SHALL equal (state == IDLE).
REQ-018 SHALL accept a request on a rising edge where req_valid && req_ready (cycle T).
REQ-019 SHALL form word index from req_addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored (aliasing wrap-around).
REQ-020 On accepted write, SHALL update only bytes with req_be[i]=1 at the accepting edge; req_be=0 SHALL leave memory unchanged but still produce a response.
REQ-021 On accepted read, SHALL capture the addressed word at the accepting edge into the response register.
REQ-022 LATENCY=1: IDLE->RESP on accept; LATENCY>1: IDLE->WAIT, counter loaded with LATENCY-2, WAIT->RESP when counter reaches 0, decrementing each cycle.
REQ-023 rsp_valid SHALL be high exactly while in RESP, first asserted in cycle T+LATENCY.
REQ-024 rsp_rdata and rsp_err SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-025 RESP->IDLE on the edge where rsp_ready=1; req_ready rises the following cycle (no accept in the same cycle as response handoff).
REQ-026 At most one request SHALL be outstanding; req_* inputs SHALL be ignored outside IDLE.
REQ-027 rsp_ready held high continuously SHALL give sustained throughput of one request per LATENCY+1 cycles.

Reset
REQ-028 reset low SHALL immediately force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1 after release.
REQ-029 Reset mid-operation SHALL drop the in-flight response; a write already committed at its accepting edge SHALL remain in memory.
REQ-030 Memory array contents SHALL NOT be reset.

Configuration
REQ-031 With DMEM_MISALIGN_CHK_EN defined, a request with req_addr[1:0]!=0 SHALL be accepted, SHALL NOT modify memory, and SHALL respond with rsp_err=1, rsp_rdata=0, same latency.
REQ-032 Without DMEM_MISALIGN_CHK_EN, req_addr[1:0] SHALL be ignored and rsp_err SHALL be constant 0.

Verification (DATA_W=32, DEPTH=64, LATENCY=2 unless stated)
REQ-033 Write 0xDEADBEEF @0x10 be=0xF, then read @0x10, rsp_ready=1 -> read rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-034 Write 0x11223344 @0x20 be=0xF, write 0xAABBCCDD @0x20 be=0x5, read @0x20 -> 0x11BB33DD.
REQ-035 Write 0x55 @0x04, read @0x104 -> 0x00000055 (alias wrap); read response held while rsp_ready=0 for 3 cycles, req_ready stays 0.
REQ-036 Assert reset in WAIT after read accept -> rsp_valid never asserts, req_ready=1 after release; prior write data still readable.
REQ-037 With DMEM_MISALIGN_CHK_EN: write 0xFFFFFFFF @0x12 -> rsp_err=1, rsp_rdata=0; read @0x10 returns unchanged value; without macro same write updates word 0x10, rsp_err=0.
REQ-038 LATENCY=1 and LATENCY=4 back-to-back reads with rsp_ready=1 -> rsp_valid at T+1 / T+4, accepts every 2 / 5 cycles.
